// File: rtl/seq_detect_moore_if.sv
// ============================================================================
// Module      : seq_detect_moore_if
// Description : Serial-stream bus of the Moore pattern detector: sampled
//               input, enable and clear towards the detector, and the detect
//               flag, prefix state and match counter coming back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_detect_moore_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8,
    parameter int SW    = $clog2(LEN + 1)
);
    logic             en;
    logic             in;
    logic             clear;
    logic             out;
    logic [SW-1:0]    state;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output en, in, clear,
        input  out, state, match_count, count_sat
    );

    modport slave (
        input  en, in, clear,
        output out, state, match_count, count_sat
    );
endinterface

`default_nettype wire

// File: rtl/seq_detect_moore.sv
// ============================================================================
// Module      : seq_detect_moore
// Description : Parametrised Moore serial pattern detector (MSB of PATTERN
//               first) with KMP-style fallback, selectable overlapping
//               detection and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_moore #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b0101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            SW      = $clog2(LEN + 1)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    seq_detect_moore_if.slave bus
);

    typedef logic [SW-1:0] state_t;

    localparam state_t c_full = state_t'(LEN);

    // Longest proper border of the full pattern: the prefix length that a
    // completed match can hand over to the next one when overlapping.
    function automatic int calc_fail();
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k < LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (PATTERN[LEN-1-j] != PATTERN[k-1-j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Next prefix length after sampling bit b in state s: the longest prefix
    // of the pattern that is a suffix of (prefix(base) followed by b).
    function automatic int calc_delta(int s, bit b);
        int base;
        int len_t;
        int idx;
        int best;
        bit ok;
        bit t_bit;
        if (s >= LEN) base = OVERLAP ? calc_fail() : 0;
        else          base = s;
        len_t = base + 1;
        best  = 0;
        for (int k = 1; k <= len_t; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                idx   = len_t - k + j;
                t_bit = (idx < base) ? PATTERN[LEN-1-idx] : b;
                if (t_bit != PATTERN[LEN-1-j]) ok = 1'b0;
            end
            if (ok && (k <= LEN)) best = k;
        end
        return best;
    endfunction

    // Transition table, one entry per (state, sampled bit), fixed at elaboration.
    state_t w_table [0:LEN][0:1];

    for (genvar s = 0; s <= LEN; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int c_next = calc_delta(s, (b == 1));
            assign w_table[s][b] = c_next[SW-1:0];
        end
    end

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_delta;
    logic             w_valid;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_sat;

    // Table lookup for the current state; out-of-range states map to empty.
    always_comb begin
        w_delta = '0;
        w_valid = 1'b0;
        for (int s = 0; s <= LEN; s++) begin
            if (r_state == state_t'(s)) begin
                w_valid = 1'b1;
                w_delta = bus.in ? w_table[s][1] : w_table[s][0];
            end
        end
    end

    assign w_sat = &r_count;

    // Next state and counter: clear beats enable; an illegal state always
    // recovers to empty; a match counts on every entry into the full state.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (bus.clear) begin
            w_state_nxt = '0;
            w_count_nxt = '0;
        end else if (!w_valid) begin
            w_state_nxt = '0;
        end else if (bus.en) begin
            w_state_nxt = w_delta;
            if ((w_delta == c_full) && !w_sat) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign bus.out         = (r_state == c_full);
    assign bus.state       = r_state;
    assign bus.match_count = r_count;
    assign bus.count_sat   = w_sat;

endmodule

`default_nettype wire
